peg_pkt_sf_fifo: RTL and testbench

PEG_PKT_SF_FIFO -- requirements
Module: peg_pkt_sf_fifo

---
 rtl/peg_pkt_sf_fifo.sv | 179 +++++++++++++++++
 tb/tb_peg_pkt_sf_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/peg_pkt_sf_fifo.sv
// Store-and-forward packet FIFO: egress only sees fully committed packets.
// Optional macro PEG_PKT_SF_FIFO_ERR_FWD_EN forwards errored packets instead of dropping them.
module peg_pkt_sf_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ing_sop,
  input  logic                    ing_eop,
  input  logic                    ing_valid,
  input  logic                    ing_error,
  input  logic [DATA_W-1:0]       ing_data,
  output logic                    ing_ready,
  output logic                    egr_sop,
  output logic                    egr_eop,
  output logic                    egr_valid,
  output logic                    egr_error,
  output logic [DATA_W-1:0]       egr_data,
  input  logic                    egr_ready,
  output logic [$clog2(DEPTH):0]  pkt_cnt,
  output logic [$clog2(DEPTH):0]  fill_lvl,
  output logic [CNT_W-1:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef PEG_PKT_SF_FIFO_ERR_FWD_EN
  localparam bit ERR_FWD = 1'b1;
`else
  localparam bit ERR_FWD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  state_t      state, state_nxt;
  logic [AW:0] wr_ptr, wr_ptr_nxt, cmt_ptr, cmt_ptr_nxt, rd_ptr;
  logic [AW:0] wr_base, end_ptr;
  logic        wr_en, take, commit, drop_inc, rdy_en, full, ing_hs, load, egr_eop_hs;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic              sop_mem  [DEPTH];
  logic              eop_mem  [DEPTH];
`ifdef PEG_PKT_SF_FIFO_ERR_FWD_EN
  logic              err_mem  [DEPTH];
`endif

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fill_lvl   = wr_ptr - rd_ptr;
  // A packet that fills the whole FIFO can never commit, so keep accepting and discard it
  assign ing_ready  = rdy_en && ((state == DROP) || !full || ((state == PKT) && (pkt_cnt == '0)));
  assign ing_hs     = ing_valid && ing_ready;
  assign load       = (cmt_ptr != rd_ptr) && (!egr_valid || egr_ready);
  assign egr_eop_hs = egr_valid && egr_ready && egr_eop;

  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    cmt_ptr_nxt = cmt_ptr;
    wr_base     = wr_ptr;
    end_ptr     = wr_ptr;
    wr_en       = 1'b0;
    take        = 1'b0;
    commit      = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (ing_hs && ing_sop) take = 1'b1;
      end
      PKT: begin
        if (full && (pkt_cnt == '0)) begin
          wr_ptr_nxt = cmt_ptr;
          drop_inc   = 1'b1;
          state_nxt  = DROP;
          if (ing_hs) begin
            if (ing_eop) state_nxt = IDLE;
            else if (ing_sop) begin
              take    = 1'b1;
              wr_base = cmt_ptr;
            end
          end
        end else if (ing_hs) begin
          take = 1'b1;
          // A sop mid-packet abandons the partial packet and restarts at the commit point
          if (ing_sop) begin
            drop_inc = 1'b1;
            wr_base  = cmt_ptr;
          end
        end
      end
      DROP: begin
        if (ing_hs) begin
          if (ing_eop) state_nxt = IDLE;
          else if (ing_sop) begin
            take    = 1'b1;
            wr_base = cmt_ptr;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take) begin
      wr_en   = 1'b1;
      end_ptr = wr_base + 1'b1;
      if (!ing_eop) begin
        wr_ptr_nxt = end_ptr;
        state_nxt  = PKT;
      end else if (ing_error && !ERR_FWD) begin
        wr_ptr_nxt = cmt_ptr;
        drop_inc   = 1'b1;
        state_nxt  = IDLE;
      end else begin
        wr_ptr_nxt  = end_ptr;
        cmt_ptr_nxt = end_ptr;
        commit      = 1'b1;
        state_nxt   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rdy_en   <= 1'b0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      cmt_ptr <= cmt_ptr_nxt;
      rdy_en  <= 1'b1;
      if (commit && !egr_eop_hs)      pkt_cnt <= pkt_cnt + 1'b1;
      else if (!commit && egr_eop_hs) pkt_cnt <= pkt_cnt - 1'b1;
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_base[AW-1:0]] <= ing_data;
      sop_mem[wr_base[AW-1:0]]  <= ing_sop;
      eop_mem[wr_base[AW-1:0]]  <= ing_eop;
`ifdef PEG_PKT_SF_FIFO_ERR_FWD_EN
      err_mem[wr_base[AW-1:0]]  <= ing_error;
`endif
    end
  end

  // One-entry output register refills in the same cycle it is drained
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr    <= '0;
      egr_valid <= 1'b0;
      egr_data  <= '0;
      egr_sop   <= 1'b0;
      egr_eop   <= 1'b0;
    end else if (load) begin
      rd_ptr    <= rd_ptr + 1'b1;
      egr_valid <= 1'b1;
      egr_data  <= data_mem[rd_ptr[AW-1:0]];
      egr_sop   <= sop_mem[rd_ptr[AW-1:0]];
      egr_eop   <= eop_mem[rd_ptr[AW-1:0]];
    end else if (egr_ready) begin
      egr_valid <= 1'b0;
    end
  end

`ifdef PEG_PKT_SF_FIFO_ERR_FWD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      egr_error <= 1'b0;
    else if (load) egr_error <= err_mem[rd_ptr[AW-1:0]];
  end
`else
  assign egr_error = 1'b0;
`endif

endmodule

// File: tb/tb_peg_pkt_sf_fifo.sv
// Directed bench for peg_pkt_sf_fifo: a DEPTH=64 instance for normal traffic and a
// DEPTH=4 instance for the oversized-packet drop path.
module tb_peg_pkt_sf_fifo;

  logic        clk, rst;
  logic        ing_sop, ing_eop, ing_valid, ing_error, egr_ready;
  logic [15:0] ing_data;

  logic        big_ing_ready, big_egr_sop, big_egr_eop, big_egr_valid, big_egr_error;
  logic [15:0] big_egr_data, big_drop_cnt;
  logic [6:0]  big_pkt_cnt, big_fill_lvl;

  logic        sm_ing_ready, sm_egr_sop, sm_egr_eop, sm_egr_valid, sm_egr_error;
  logic [15:0] sm_egr_data, sm_drop_cnt;
  logic [2:0]  sm_pkt_cnt, sm_fill_lvl;

  logic [18:0] big_q[$];
  logic [18:0] sm_q[$];
  logic        use_small;
  int          errors, checks;
  logic [15:0] exp_data [5];
  logic [6:0]  exp_pkt  [5];

  peg_pkt_sf_fifo #(.DATA_W(16), .DEPTH(64), .CNT_W(16)) u_big (
    .clk(clk), .rst(rst),
    .ing_sop(ing_sop), .ing_eop(ing_eop), .ing_valid(ing_valid), .ing_error(ing_error),
    .ing_data(ing_data), .ing_ready(big_ing_ready),
    .egr_sop(big_egr_sop), .egr_eop(big_egr_eop), .egr_valid(big_egr_valid),
    .egr_error(big_egr_error), .egr_data(big_egr_data), .egr_ready(egr_ready),
    .pkt_cnt(big_pkt_cnt), .fill_lvl(big_fill_lvl), .drop_cnt(big_drop_cnt)
  );

  peg_pkt_sf_fifo #(.DATA_W(16), .DEPTH(4), .CNT_W(16)) u_small (
    .clk(clk), .rst(rst),
    .ing_sop(ing_sop), .ing_eop(ing_eop), .ing_valid(ing_valid), .ing_error(ing_error),
    .ing_data(ing_data), .ing_ready(sm_ing_ready),
    .egr_sop(sm_egr_sop), .egr_eop(sm_egr_eop), .egr_valid(sm_egr_valid),
    .egr_error(sm_egr_error), .egr_data(sm_egr_data), .egr_ready(egr_ready),
    .pkt_cnt(sm_pkt_cnt), .fill_lvl(sm_fill_lvl), .drop_cnt(sm_drop_cnt)
  );

  always #5 clk = ~clk;

  // Record every egress handshake half a cycle before the edge that completes it
  always @(negedge clk) begin
    if (rst && big_egr_valid && egr_ready)
      big_q.push_back({big_egr_error, big_egr_sop, big_egr_eop, big_egr_data});
    if (rst && sm_egr_valid && egr_ready)
      sm_q.push_back({sm_egr_error, sm_egr_sop, sm_egr_eop, sm_egr_data});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic e, input logic er, input logic [15:0] d);
    logic rdy;
    logic done;
    done      = 1'b0;
    ing_sop   = s;
    ing_eop   = e;
    ing_error = er;
    ing_data  = d;
    ing_valid = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      rdy = use_small ? sm_ing_ready : big_ing_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    ing_valid = 1'b0;
    ing_sop   = 1'b0;
    ing_eop   = 1'b0;
    ing_error = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL ing_handshake: got no ready expected ready within 200 cycles");
    end
  endtask

  task automatic resetDut();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    big_q.delete();
    sm_q.delete();
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; use_small = 1'b0;
    ing_sop = 1'b0; ing_eop = 1'b0; ing_valid = 1'b0; ing_error = 1'b0;
    ing_data = '0; egr_ready = 1'b1;
    errors = 0; checks = 0;

    // Reset values while rst is held low
    repeat (2) tick();
    checkOutput("rst_ing_ready", big_ing_ready, 0);
    checkOutput("rst_egr_valid", big_egr_valid, 0);
    checkOutput("rst_egr_data",  big_egr_data, 0);
    checkOutput("rst_pkt_cnt",   big_pkt_cnt, 0);
    checkOutput("rst_fill_lvl",  big_fill_lvl, 0);
    checkOutput("rst_drop_cnt",  big_drop_cnt, 0);
    checkOutput("rst_sm_ready",  sm_ing_ready, 0);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_ready",    big_ing_ready, 1);
    checkOutput("post_rst_sm_ready", sm_ing_ready, 1);

    // Three-beat packet, egress latency and order
    applyStimulus(1, 0, 0, 16'h0001);
    applyStimulus(0, 0, 0, 16'h0002);
    applyStimulus(0, 1, 0, 16'h0003);
    checkOutput("t1_valid_early", big_egr_valid, 0);
    checkOutput("t1_pkt_cnt1",    big_pkt_cnt, 1);
    checkOutput("t1_fill3",       big_fill_lvl, 3);
    tick();
    checkOutput("t1_valid_b1", big_egr_valid, 1);
    checkOutput("t1_data_b1",  big_egr_data, 16'h0001);
    checkOutput("t1_sop_b1",   big_egr_sop, 1);
    checkOutput("t1_eop_b1",   big_egr_eop, 0);
    tick();
    checkOutput("t1_data_b2",  big_egr_data, 16'h0002);
    checkOutput("t1_sop_b2",   big_egr_sop, 0);
    tick();
    checkOutput("t1_data_b3",  big_egr_data, 16'h0003);
    checkOutput("t1_eop_b3",   big_egr_eop, 1);
    checkOutput("t1_pkt_b3",   big_pkt_cnt, 1);
    tick();
    checkOutput("t1_valid_end", big_egr_valid, 0);
    checkOutput("t1_pkt_cnt0",  big_pkt_cnt, 0);
    checkOutput("t1_fill0",     big_fill_lvl, 0);
    checkOutput("t1_beats",     big_q.size(), 3);

    // Five-beat packet with ing_error on the eop beat
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 0, i == 4, i == 4, 16'h0010 + 16'(i));
      if (i == 3) checkOutput("t2_fill4", big_fill_lvl, 4);
    end
    repeat (8) tick();
`ifdef PEG_PKT_SF_FIFO_ERR_FWD_EN
    checkOutput("t2_beats",    big_q.size(), 5);
    checkOutput("t2_drop_cnt", big_drop_cnt, 0);
    if (big_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        checkOutput("t2_err_bit", big_q[i][18], (i == 4) ? 1 : 0);
        checkOutput("t2_data",    big_q[i][15:0], 16'h0010 + 16'(i));
      end
    end
`else
    checkOutput("t2_beats",    big_q.size(), 0);
    checkOutput("t2_drop_cnt", big_drop_cnt, 1);
    checkOutput("t2_fill0",    big_fill_lvl, 0);
    checkOutput("t2_pkt_cnt",  big_pkt_cnt, 0);
`endif

    // DEPTH=4: six-beat packet cannot fit and is discarded, then a two-beat packet
    resetDut();
    use_small = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checkOutput("t3_ready_drop", sm_ing_ready, 1);
      applyStimulus(i == 0, i == 5, 0, 16'h0020 + 16'(i));
    end
    checkOutput("t3_drop_cnt_mid", sm_drop_cnt, 1);
    applyStimulus(1, 0, 0, 16'h0030);
    applyStimulus(0, 1, 0, 16'h0031);
    repeat (6) tick();
    use_small = 1'b0;
    checkOutput("t3_drop_cnt", sm_drop_cnt, 1);
    checkOutput("t3_beats",    sm_q.size(), 2);
    checkOutput("t3_pkt_cnt",  sm_pkt_cnt, 0);
    checkOutput("t3_fill0",    sm_fill_lvl, 0);
    if (sm_q.size() == 2) begin
      checkOutput("t3_beat0", sm_q[0], 19'h20030);
      checkOutput("t3_beat1", sm_q[1], 19'h10031);
    end

    // Stalled egress with three single-beat packets, then ready toggling
    resetDut();
    egr_ready = 1'b0;
    applyStimulus(1, 1, 0, 16'h0041);
    applyStimulus(1, 1, 0, 16'h0042);
    applyStimulus(1, 1, 0, 16'h0043);
    checkOutput("t4_pkt_cnt3", big_pkt_cnt, 3);
    checkOutput("t4_valid",    big_egr_valid, 1);
    checkOutput("t4_data",     big_egr_data, 16'h0041);
    repeat (2) tick();
    checkOutput("t4_stall_data",  big_egr_data, 16'h0041);
    checkOutput("t4_stall_sop",   big_egr_sop, 1);
    checkOutput("t4_stall_eop",   big_egr_eop, 1);
    checkOutput("t4_stall_valid", big_egr_valid, 1);
    exp_data = '{16'h0041, 16'h0042, 16'h0042, 16'h0043, 16'h0043};
    exp_pkt  = '{7'd3, 7'd2, 7'd2, 7'd1, 7'd1};
    for (int c = 0; c < 5; c++) begin
      egr_ready = (c % 2 == 0);
      checkOutput("t4_tog_valid", big_egr_valid, 1);
      checkOutput("t4_tog_data",  big_egr_data, exp_data[c]);
      checkOutput("t4_tog_pkt",   big_pkt_cnt, exp_pkt[c]);
      tick();
    end
    egr_ready = 1'b0;
    checkOutput("t4_valid_end", big_egr_valid, 0);
    checkOutput("t4_pkt_cnt0",  big_pkt_cnt, 0);
    checkOutput("t4_beats",     big_q.size(), 3);
    if (big_q.size() == 3) begin
      checkOutput("t4_order0", big_q[0], 19'h30041);
      checkOutput("t4_order1", big_q[1], 19'h30042);
      checkOutput("t4_order2", big_q[2], 19'h30043);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
